// File: rtl/ex_div_pkg.sv
// ex_div_pkg -- shared definitions for the EX-stage divider.
//   div_state_e : divider FSM state encodings (free, divide-by-zero, running, done)
//   READY/NOT_READY, START/STOP : handshake levels used on ready_o and start_i
package ex_div_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic READY     = 1'b1;
  localparam logic NOT_READY = 1'b0;
  localparam logic START     = 1'b1;
  localparam logic STOP      = 1'b0;

endpackage

// File: rtl/ex_div.sv
// ex_div -- multi-cycle radix-2 restoring divider for the EX stage (DIV/DIVU).
// Ports:
//   clk           : clock, all state updates on the rising edge
//   rst           : asynchronous active-low reset
//   signed_div_i  : 1 = signed divide, 0 = unsigned; sampled with start_i
//   opdata1_i     : dividend, sampled with start_i
//   opdata2_i     : divisor, sampled with start_i
//   start_i       : request, held high until the result is consumed
//   annul_i       : abort an in-flight divide (flush/exception)
//   result_o      : {remainder, quotient}, registered
//   ready_o       : result_o valid, registered
// The EX stage stalls while start_i=1 and ready_o=0.
module ex_div
  import ex_div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  div_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0]       dsor_q, dsor_d;     // divisor magnitude
  logic [DATA_W-1:0]       quo_q, quo_d;       // dividend magnitude shifting out, quotient shifting in
  logic [DATA_W-1:0]       rem_q, rem_d;       // partial remainder
  logic                    neg_quo_q, neg_quo_d;
  logic                    neg_rem_q, neg_rem_d;
  logic                    ready_q, ready_d;
  logic [2*DATA_W-1:0]     result_q, result_d;

  // One extra bit so the shifted remainder (< 2*divisor) never overflows.
  logic [DATA_W:0]         rem_shift;
  logic [DATA_W:0]         rem_diff;

  // Magnitude of an operand; the most negative value maps onto its unsigned
  // bit pattern, which is exactly the magnitude needed.
  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v,
                                            input logic              is_signed);
    logic signed [DATA_W-1:0] sv;
    sv = v;
    if (is_signed && (sv < 0)) return -sv;
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v,
                                                   input logic              neg);
    return neg ? -v : v;
  endfunction

  assign rem_shift = {rem_q, quo_q[DATA_W-1]};
  assign rem_diff  = rem_shift - {1'b0, dsor_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dsor_d    = dsor_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    ready_d   = NOT_READY;
    result_d  = '0;

    case (state_q)
      DIV_FREE: begin
        if ((start_i == START) && !annul_i) begin
          dsor_d    = mag(opdata2_i, signed_div_i);
          rem_d     = '0;
          cnt_d     = '0;
          neg_quo_d = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
          neg_rem_d = signed_div_i & opdata1_i[DATA_W-1];
          if (opdata2_i == '0) begin
            // Zeroed quotient/remainder make the END result 0 for free.
            quo_d   = '0;
            state_d = DIV_BYZERO;
          end else begin
            quo_d   = mag(opdata1_i, signed_div_i);
            state_d = DIV_ON;
          end
        end
      end

      DIV_BYZERO: begin
        state_d = annul_i ? DIV_FREE : DIV_END;
      end

      DIV_ON: begin
        if (annul_i) begin
          state_d = DIV_FREE;
        end else begin
          // Negative difference (top bit set) means restore.
          if (!rem_diff[DATA_W]) begin
            rem_d = rem_diff[DATA_W-1:0];
            quo_d = (quo_q << 1) | DATA_W'(1);
          end else begin
            rem_d = rem_shift[DATA_W-1:0];
            quo_d = quo_q << 1;
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = DIV_END;
        end
      end

      DIV_END: begin
        // annul_i is deliberately ignored: the result is already committed.
        if (start_i == START) begin
          ready_d  = READY;
          result_d = {apply_sign(rem_q, neg_rem_q), apply_sign(quo_q, neg_quo_q)};
        end else begin
          state_d = DIV_FREE;
        end
      end

      default: state_d = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= DIV_FREE;
      cnt_q     <= '0;
      dsor_q    <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ready_q   <= NOT_READY;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dsor_q    <= dsor_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      ready_q   <= ready_d;
      result_q  <= result_d;
    end
  end

  assign ready_o  = ready_q;
  assign result_o = result_q;

endmodule
